// File: rtl/floo_route_arb.sv
// Round-robin sharing of one route-computation lookup among NumReq requesters,
// with a registered per-requester response slot (valid/ready).
module floo_route_arb #(
  parameter int unsigned NumReq = 4,
  parameter type         addr_t = logic,
  parameter type         id_t   = logic
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic  [NumReq-1:0]       req_valid_i,
  output logic  [NumReq-1:0]       req_ready_o,
  input  addr_t [NumReq-1:0]       req_addr_i,
  output addr_t                    lookup_addr_o,
  input  id_t                      lookup_id_i,
  input  logic                     lookup_err_i,
  output logic  [NumReq-1:0]       rsp_valid_o,
  input  logic  [NumReq-1:0]       rsp_ready_i,
  output id_t   [NumReq-1:0]       rsp_id_o,
  output logic  [NumReq-1:0]       rsp_err_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  typedef logic [IdxW-1:0] idx_t;

  if (NumReq < 2) begin : gen_param_check
    $error("floo_route_arb: NumReq must be at least 2");
  end

  idx_t              last_q;
  logic [NumReq-1:0] rsp_valid_q;
  id_t  [NumReq-1:0] rsp_id_q;
  logic [NumReq-1:0] rsp_err_q;

  logic [NumReq-1:0] eligible;
  logic [NumReq-1:0] gnt;
  logic              gnt_valid;
  idx_t              gnt_idx;
  idx_t              cand;

  // A slot being drained this cycle can be refilled in the same cycle.
  assign eligible = req_valid_i & (~rsp_valid_q | rsp_ready_i);

  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = last_q;
    cand      = last_q;
    if (!rst_i) begin
      for (int unsigned off = 1; off <= NumReq; off++) begin
        cand = idx_t'((32'(last_q) + off) % NumReq);
        if (!gnt_valid && eligible[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
    if (gnt_valid) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  assign req_ready_o   = gnt;
  assign lookup_addr_o = gnt_valid ? req_addr_i[gnt_idx] : addr_t'('0);

  // A grant always wins over a consume so a reused slot stays valid with new data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q      <= idx_t'(NumReq - 1);
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= '0;
    end else begin
      if (gnt_valid) begin
        last_q <= gnt_idx;
      end
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (gnt[i]) begin
          rsp_valid_q[i] <= 1'b1;
          rsp_id_q[i]    <= lookup_id_i;
          rsp_err_q[i]   <= lookup_err_i;
        end else if (rsp_ready_i[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_err_o   = rsp_err_q;

  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(req_ready_o));

  for (genvar i = 0; i < NumReq; i++) begin : gen_rsp_stable
    a_rsp_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (rsp_valid_o[i] && !rsp_ready_i[i]) |=>
        ($stable(rsp_id_o[i]) && $stable(rsp_err_o[i])));
  end

endmodule

// File: tb/tb_floo_route_arb.sv
// Directed table-driven bench for floo_route_arb with NumReq=4, 8-bit addresses
// and 4-bit IDs; the lookup is modelled as id = addr[3:0] ^ 4'hA.
module tb_floo_route_arb;

  typedef logic [7:0] addr_t;
  typedef logic [3:0] id_t;

  logic             clk;
  logic             rst;
  logic [3:0]       req_valid;
  logic [3:0]       req_ready;
  addr_t [3:0]      req_addr;
  addr_t            lookup_addr;
  id_t              lookup_id;
  logic             lookup_err;
  logic [3:0]       rsp_valid;
  logic [3:0]       rsp_ready;
  id_t  [3:0]       rsp_id;
  logic [3:0]       rsp_err;

  int total = 0;
  int bad   = 0;

  floo_route_arb #(
    .NumReq(4),
    .addr_t(addr_t),
    .id_t  (id_t)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .lookup_addr_o(lookup_addr),
    .lookup_id_i  (lookup_id),
    .lookup_err_i (lookup_err),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_err_o    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the shared route computation: combinational on the lookup address.
  assign lookup_id = lookup_addr[3:0] ^ 4'hA;

  function automatic id_t idOf(input addr_t a);
    return a[3:0] ^ 4'hA;
  endfunction

  typedef struct packed {
    logic       rst;
    logic [3:0] rv;
    logic [3:0] rr;
    logic       err;
    logic [3:0] exp_rdy;
    logic [3:0] exp_rspv;
  } vec_t;

  vec_t  vecs [24];
  id_t   exp_id  [4];
  logic  exp_err [4];
  addr_t exp_addr;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst        = v.rst;
    req_valid  = v.rv;
    rsp_ready  = v.rr;
    lookup_err = v.err;
    #1;
  endtask

  initial begin
    // Rows: rst, req_valid, rsp_ready, lookup_err, expected req_ready, expected rsp_valid.
    vecs[0]  = '{1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 4'h0};
    vecs[1]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h1, 4'h0};
    vecs[2]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h2, 4'h1};
    vecs[3]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h4, 4'h2};
    vecs[4]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h8, 4'h4};
    vecs[5]  = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h1, 4'h8};
    vecs[6]  = '{1'b0, 4'hF, 4'hD, 1'b0, 4'h2, 4'h1};
    vecs[7]  = '{1'b0, 4'hF, 4'hD, 1'b0, 4'h4, 4'h2};
    vecs[8]  = '{1'b0, 4'hF, 4'hD, 1'b0, 4'h8, 4'h6};
    vecs[9]  = '{1'b0, 4'hF, 4'hD, 1'b0, 4'h1, 4'hA};
    vecs[10] = '{1'b0, 4'hF, 4'hD, 1'b0, 4'h4, 4'h3};
    vecs[11] = '{1'b0, 4'hF, 4'hD, 1'b0, 4'h8, 4'h6};
    vecs[12] = '{1'b0, 4'hF, 4'hD, 1'b0, 4'h1, 4'hA};
    vecs[13] = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h2, 4'h3};
    vecs[14] = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h4, 4'h2};
    vecs[15] = '{1'b0, 4'h8, 4'hF, 1'b1, 4'h8, 4'h4};
    vecs[16] = '{1'b0, 4'h8, 4'hF, 1'b0, 4'h8, 4'h8};
    vecs[17] = '{1'b0, 4'h0, 4'hF, 1'b0, 4'h0, 4'h8};
    vecs[18] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0};
    vecs[19] = '{1'b0, 4'h3, 4'h0, 1'b0, 4'h1, 4'h0};
    vecs[20] = '{1'b0, 4'h3, 4'h0, 1'b0, 4'h2, 4'h1};
    vecs[21] = '{1'b0, 4'h3, 4'h0, 1'b0, 4'h0, 4'h3};
    vecs[22] = '{1'b1, 4'h3, 4'h0, 1'b0, 4'h0, 4'h3};
    vecs[23] = '{1'b0, 4'hF, 4'hF, 1'b0, 4'h1, 4'h0};

    for (int i = 0; i < 4; i++) begin
      req_addr[i] = 8'h30 + 8'(i * 8'h11);
      exp_id[i]   = '0;
      exp_err[i]  = 1'b0;
    end
    rst        = 1'b1;
    req_valid  = 4'hF;
    rsp_ready  = 4'hF;
    lookup_err = 1'b0;
    @(posedge clk);

    for (int r = 0; r < 24; r++) begin
      applyStimulus(vecs[r]);
      exp_addr = '0;
      for (int i = 0; i < 4; i++) begin
        if (vecs[r].exp_rdy[i]) exp_addr = req_addr[i];
      end
      checkOutput($sformatf("row%0d req_ready", r), 16'(req_ready), 16'(vecs[r].exp_rdy));
      checkOutput($sformatf("row%0d lookup_addr", r), 16'(lookup_addr), 16'(exp_addr));
      checkOutput($sformatf("row%0d rsp_valid", r), 16'(rsp_valid), 16'(vecs[r].exp_rspv));
      if (r > 0 && vecs[r-1].rst) begin
        checkOutput($sformatf("row%0d reset rsp_id", r), 16'(rsp_id), 16'h0000);
        checkOutput($sformatf("row%0d reset rsp_err", r), 16'(rsp_err), 16'h0000);
      end
      for (int i = 0; i < 4; i++) begin
        if (vecs[r].exp_rspv[i]) begin
          checkOutput($sformatf("row%0d rsp_id[%0d]", r, i), 16'(rsp_id[i]), 16'(exp_id[i]));
          checkOutput($sformatf("row%0d rsp_err[%0d]", r, i), 16'(rsp_err[i]), 16'(exp_err[i]));
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (vecs[r].rst) begin
          exp_id[i]  = '0;
          exp_err[i] = 1'b0;
        end else if (vecs[r].exp_rdy[i]) begin
          exp_id[i]  = idOf(req_addr[i]);
          exp_err[i] = vecs[r].err;
        end
      end
    end

    // Requester 2 alone with a new address every cycle reuses its slot back to back.
    @(negedge clk);
    req_valid = 4'h4; rsp_ready = 4'hF; lookup_err = 1'b0; req_addr[2] = 8'h75;
    #1;
    checkOutput("reuse A ready", 16'(req_ready), 16'h0004);
    checkOutput("reuse A lookup", 16'(lookup_addr), 16'h0075);
    @(negedge clk);
    req_addr[2] = 8'h86;
    #1;
    checkOutput("reuse B ready", 16'(req_ready), 16'h0004);
    checkOutput("reuse B rsp_valid2", 16'(rsp_valid[2]), 16'h0001);
    checkOutput("reuse B rsp_id2", 16'(rsp_id[2]), 16'hF);
    @(negedge clk);
    req_addr[2] = 8'h97;
    #1;
    checkOutput("reuse C ready", 16'(req_ready), 16'h0004);
    checkOutput("reuse C rsp_valid2", 16'(rsp_valid[2]), 16'h0001);
    checkOutput("reuse C rsp_id2", 16'(rsp_id[2]), 16'hC);
    @(negedge clk);
    req_valid = 4'h0;
    #1;
    checkOutput("reuse end ready", 16'(req_ready), 16'h0000);
    checkOutput("reuse end rsp_valid2", 16'(rsp_valid[2]), 16'h0001);
    checkOutput("reuse end rsp_id2", 16'(rsp_id[2]), 16'hD);
    @(negedge clk);
    #1;
    checkOutput("reuse drained rsp_valid", 16'(rsp_valid), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
